// File: rtl/udp_tx_sched.sv
// Two-source round-robin scheduler for a shared UDP/GMII transmit engine.
// Handles the start handshake, word routing, inter-frame gap and the completion timeout.
module udp_tx_sched #(
  parameter logic [15:0] MAX_BYTES      = 16'd1472,
  parameter int unsigned IFG_CYCLES     = 12,
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd200000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        src0_req_i,
  input  logic [15:0] src0_byte_num_i,
  input  logic [31:0] src0_data_i,
  output logic        src0_rd_o,
  output logic        src0_done_o,
  output logic        src0_err_o,
  input  logic        src1_req_i,
  input  logic [15:0] src1_byte_num_i,
  input  logic [31:0] src1_data_i,
  output logic        src1_rd_o,
  output logic        src1_done_o,
  output logic        src1_err_o,
  output logic        tx_start_en_o,
  output logic [15:0] tx_byte_num_o,
  output logic [31:0] tx_data_o,
  input  logic        tx_req_i,
  input  logic        tx_done_i,
  output logic        busy_o
);

  localparam int unsigned TO_W  = 20;
  localparam int unsigned IFG_W = 8;
  localparam int unsigned BN_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2,
    ST_IFG   = 2'd3
  } state_e;

  state_e            state_q;
  logic              grant_q;
  logic              last_grant_q;
  logic              hold_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic [IFG_W-1:0]  ifg_cnt_q;
  logic [1:0]        done_q;
  logic [1:0]        err_q;
  logic              start_q;
  logic              busy_q;
  logic [BN_W-1:0]   byte_num_q;

  logic              any_req;
  logic              win;
  logic [BN_W-1:0]   win_bytes;
  logic              win_bad;

  // Round-robin pick: on contention the source not granted last wins.
  always_comb begin
    any_req = src0_req_i | src1_req_i;
    win     = src1_req_i;
    if (src0_req_i && src1_req_i) begin
      win = ~last_grant_q;
    end
    win_bytes = win ? src1_byte_num_i : src0_byte_num_i;
    win_bad   = (win_bytes == BN_W'(0)) || (win_bytes > MAX_BYTES);
  end

  // hold_q skips arbitration for one IDLE cycle after a done pulse or IFG exit,
  // so a source that drops req on done is not re-evaluated and start pulses stay spaced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      hold_q       <= 1'b0;
      to_cnt_q     <= '0;
      ifg_cnt_q    <= '0;
      done_q       <= '0;
      err_q        <= '0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      byte_num_q   <= '0;
    end else begin
      start_q <= 1'b0;
      done_q  <= '0;
      err_q   <= '0;
      hold_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (any_req && !hold_q) begin
            if (win_bad) begin
              done_q[win] <= 1'b1;
              err_q[win]  <= 1'b1;
              hold_q      <= 1'b1;
            end else begin
              grant_q      <= win;
              last_grant_q <= win;
              byte_num_q   <= win_bytes;
              start_q      <= 1'b1;
              busy_q       <= 1'b1;
              state_q      <= ST_START;
            end
          end
        end
        ST_START: begin
          to_cnt_q <= '0;
          state_q  <= ST_BUSY;
        end
        ST_BUSY: begin
          to_cnt_q <= to_cnt_q + TO_W'(1);
          if (tx_done_i) begin
            done_q[grant_q] <= 1'b1;
            to_cnt_q        <= '0;
            ifg_cnt_q       <= '0;
            state_q         <= ST_IFG;
          end else if (to_cnt_q == TIMEOUT_CYCLES - TO_W'(1)) begin
            done_q[grant_q] <= 1'b1;
            err_q[grant_q]  <= 1'b1;
            ifg_cnt_q       <= '0;
            state_q         <= ST_IFG;
          end
        end
        ST_IFG: begin
          if (ifg_cnt_q == IFG_W'(IFG_CYCLES - 1)) begin
            busy_q  <= 1'b0;
            hold_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            ifg_cnt_q <= ifg_cnt_q + IFG_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Zero-latency word routing while a frame is in flight.
  always_comb begin
    tx_data_o = '0;
    src0_rd_o = 1'b0;
    src1_rd_o = 1'b0;
    if (state_q == ST_BUSY) begin
      tx_data_o = grant_q ? src1_data_i : src0_data_i;
      src0_rd_o = tx_req_i & ~grant_q;
      src1_rd_o = tx_req_i & grant_q;
    end
  end

  assign tx_start_en_o = start_q;
  assign tx_byte_num_o = byte_num_q;
  assign busy_o        = busy_q;
  assign src0_done_o   = done_q[0];
  assign src1_done_o   = done_q[1];
  assign src0_err_o    = err_q[0];
  assign src1_err_o    = err_q[1];

endmodule

// File: tb/tb_udp_tx_sched.sv
// Directed bench for udp_tx_sched; a second instance with a short timeout covers expiry.
module tb_udp_tx_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        src0_req, src1_req;
  logic [15:0] src0_bn, src1_bn;
  logic [31:0] src0_data, src1_data;
  logic        tx_req, tx_done;

  logic        rd0, rd1, done0, done1, err0, err1, start, busy;
  logic [15:0] bn;
  logic [31:0] txd;

  logic        t_rd0, t_rd1, t_done0, t_done1, t_err0, t_err1, t_start, t_busy;
  logic [15:0] t_bn;
  logic [31:0] t_txd;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int prev_start = 0;

  always #5 clk = ~clk;

  udp_tx_sched dut (
    .clk(clk), .rst_n(rst_n),
    .src0_req_i(src0_req), .src0_byte_num_i(src0_bn), .src0_data_i(src0_data),
    .src0_rd_o(rd0), .src0_done_o(done0), .src0_err_o(err0),
    .src1_req_i(src1_req), .src1_byte_num_i(src1_bn), .src1_data_i(src1_data),
    .src1_rd_o(rd1), .src1_done_o(done1), .src1_err_o(err1),
    .tx_start_en_o(start), .tx_byte_num_o(bn), .tx_data_o(txd),
    .tx_req_i(tx_req), .tx_done_i(tx_done), .busy_o(busy)
  );

  udp_tx_sched #(.TIMEOUT_CYCLES(20'd50)) dut_to (
    .clk(clk), .rst_n(rst_n),
    .src0_req_i(src0_req), .src0_byte_num_i(src0_bn), .src0_data_i(src0_data),
    .src0_rd_o(t_rd0), .src0_done_o(t_done0), .src0_err_o(t_err0),
    .src1_req_i(src1_req), .src1_byte_num_i(src1_bn), .src1_data_i(src1_data),
    .src1_rd_o(t_rd1), .src1_done_o(t_done1), .src1_err_o(t_err1),
    .tx_start_en_o(t_start), .tx_byte_num_o(t_bn), .tx_data_o(t_txd),
    .tx_req_i(tx_req), .tx_done_i(tx_done), .busy_o(t_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait for a start, check routing with tx_req pulses, then finish the frame after len cycles.
  task automatic do_frame(input int src, input logic [15:0] exp_bn, input int len);
    int n = 0;
    while (!start && n < 60) begin
      tick();
      n++;
    end
    chk("start_seen", 32'(start), 32'd1);
    prev_start = start_cyc;
    start_cyc  = cyc;
    chk("start_bytes", 32'(bn), 32'(exp_bn));
    chk("busy_in_start", 32'(busy), 32'd1);
    tick();
    chk("start_one_cycle", 32'(start), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tx_req = 1'b1;
      #1;
      chk("rd0_mirror", 32'(rd0), (src == 0) ? 32'd1 : 32'd0);
      chk("rd1_mirror", 32'(rd1), (src == 1) ? 32'd1 : 32'd0);
      chk("tx_data_mux", txd, (src == 1) ? src1_data : src0_data);
      tick();
      tx_req = 1'b0;
      #1;
      chk("rd_idle", 32'({rd1, rd0}), 32'd0);
      tick();
    end
    for (int i = 7; i < len; i++) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("done0", 32'(done0), (src == 0) ? 32'd1 : 32'd0);
    chk("done1", 32'(done1), (src == 1) ? 32'd1 : 32'd0);
    chk("done_err", 32'({err1, err0}), 32'd0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    chk("idle_reached", 32'(busy), 32'd0);
    tick();
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; src0_req = 1'b0; src1_req = 1'b0;
    src0_bn = 16'd100; src1_bn = 16'd200;
    src0_data = 32'hDEAD_BEEF; src1_data = 32'hA5A5_0102;
    tx_req = 1'b0; tx_done = 1'b0;
    #1;
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd", 32'({rd1, rd0}), 32'd0);
    chk("rst_done_err", 32'({done1, done0, err1, err0}), 32'd0);
    chk("rst_bn", 32'(bn), 32'd0);
    chk("rst_txd", txd, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Single src0 frame, tx_done 200 cycles after start, busy drops 12 cycles after done
    src0_req = 1'b1;
    do_frame(0, 16'd100, 200);
    src0_req = 1'b0;
    chk("t1_busy_at_done", 32'(busy), 32'd1);
    tick();
    chk("t1_done_pulse_width", 32'(done0), 32'd0);
    for (int i = 0; i < 10; i++) tick();
    chk("t1_busy_ifg_end", 32'(busy), 32'd1);
    tick();
    chk("t1_busy_fall", 32'(busy), 32'd0);
    chk("t1_bn_held", 32'(bn), 32'd100);

    // Both requests held through reset: src0 first, then src1 exactly 35 cycles later
    rst_n = 1'b0;
    src0_bn = 16'd64; src1_bn = 16'd200;
    src0_req = 1'b1; src1_req = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    do_frame(0, 16'd64, 20);
    src0_req = 1'b0;
    tick();
    src0_req = 1'b1;
    do_frame(1, 16'd200, 20);
    chk("t2_start_gap", 32'(start_cyc - prev_start), 32'd35);

    // Continuous src1 with src0 re-requesting: grants keep alternating
    do_frame(0, 16'd64, 10);
    src0_req = 1'b0;
    tick();
    src0_req = 1'b1;
    do_frame(1, 16'd200, 10);
    do_frame(0, 16'd64, 10);
    src0_req = 1'b0; src1_req = 1'b0;
    wait_idle();

    // Zero-length and oversize rejects, then the largest legal size is accepted
    src0_bn = 16'd0; src0_req = 1'b1;
    tick();
    chk("rej0_done", 32'({done0, err0}), 32'h3);
    chk("rej0_no_start", 32'({start, busy, done1}), 32'd0);
    src0_req = 1'b0;
    tick();
    chk("rej0_pulse_width", 32'(done0), 32'd0);
    src1_bn = 16'd1473; src1_req = 1'b1;
    tick();
    chk("rej1_done", 32'({done1, err1}), 32'h3);
    chk("rej1_other", 32'(done0), 32'd0);
    src1_req = 1'b0;
    tick();
    chk("rej1_no_start", 32'({start, busy}), 32'd0);
    src1_bn = 16'd1472; src1_req = 1'b1;
    do_frame(1, 16'd1472, 10);
    src1_req = 1'b0;
    wait_idle();

    // Timeout instance: no tx_done, expiry 50 cycles after BUSY entry
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    src0_bn = 16'd100; src0_req = 1'b1;
    tick();
    chk("to_start", 32'(t_start), 32'd1);
    chk("to_bn", 32'(t_bn), 32'd100);
    tick();
    for (int i = 0; i < 49; i++) tick();
    chk("to_not_yet", 32'(t_done0), 32'd0);
    tick();
    chk("to_done_err", 32'({t_done0, t_err0}), 32'h3);
    chk("to_other", 32'({t_done1, t_err1}), 32'd0);
    src0_req = 1'b0;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("to_late_done_ignored", 32'({t_done0, t_err0}), 32'd0);
    chk("to_ifg_busy", 32'(t_busy), 32'd1);
    chk("to_ifg_outputs", 32'({t_rd1, t_rd0}) | t_txd, 32'd0);
    wait_idle();

    // Reset in mid-BUSY clears every output immediately
    src0_data = 32'h1234_5678;
    src0_req = 1'b1;
    tick();
    chk("rb_start", 32'(start), 32'd1);
    tick();
    tx_req = 1'b1;
    #1;
    chk("rb_rd_before", 32'(rd0), 32'd1);
    chk("rb_txd_before", txd, 32'h1234_5678);
    rst_n = 1'b0;
    #1;
    chk("rb_busy", 32'(busy), 32'd0);
    chk("rb_rd", 32'({rd1, rd0}), 32'd0);
    chk("rb_txd", txd, 32'd0);
    chk("rb_bn", 32'(bn), 32'd0);
    chk("rb_misc", 32'({start, done1, done0, err1, err0}), 32'd0);
    tx_req = 1'b0; src0_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/udp_tx_sched.md
# udp_tx_sched

Two-source transmit scheduler that shares the single UDP/GMII transmit engine between requesters, for example a video-line source and a control/status source. It runs round-robin arbitration and issues the engine's start pulse and byte count. While a frame is in flight it routes the engine's word requests and data between the engine and the granted source. It also enforces an inter-frame gap and guards each frame with a completion timeout. It sits directly upstream of the UDP transmit engine in the same clock domain.

## Interface
Parameters:
- MAX_BYTES, 16'd1472: largest legal payload byte count per frame.
- IFG_CYCLES, 12: idle cycles between a frame's end and the next start. Legal range is 2 to 255.
- TIMEOUT_CYCLES, 20'd200000: number of BUSY cycles without `tx_done` before the frame is aborted.

Ports:
- clk  in  1  system clock (single clock domain).
- rst_n  in  1  asynchronous, active-low reset.
- src0_req / src1_req  in  1  level request; held high until the matching `srcN_done`.
- src0_byte_num / src1_byte_num  in  16  payload byte count; stable while `srcN_req` is high.
- src0_data / src1_data  in  32  current payload word, MSB byte first.
- src0_rd / src1_rd  out  1  word-advance strobe to the source.
- src0_done / src1_done  out  1  one-cycle completion pulse.
- src0_err / src1_err  out  1  qualifies `srcN_done`; 1 means rejected or timed out.
- tx_start_en  out  1  one-cycle start pulse to the engine.
- tx_byte_num  out  16  byte count to the engine.
- tx_data  out  32  payload word to the engine.
- tx_req  in  1  engine word request.
- tx_done  in  1  engine frame-complete pulse.
- busy  out  1  high in every state except IDLE.

## Operation
- State machine with four states: IDLE, START, BUSY, IFG.
- IDLE:
  - If any `srcN_req` is high, select a winner by round-robin: the source not granted last wins.
  - `last_grant` resets to 1, so `src0` wins the first simultaneous request.
  - If the winner's byte_num is 0 or greater than MAX_BYTES, the request is rejected: pulse `srcN_done` and `srcN_err` together, do not update `last_grant`, and stay in IDLE.
  - Otherwise register `grant` and `tx_byte_num`, update `last_grant`, and go to START.
- START:
  - Drive `tx_start_en` = 1 for exactly this one cycle.
  - Clear the timeout counter.
  - Go to BUSY.
- BUSY:
  - `tx_data` = `srcN_data` of the granted source (combinational mux).
  - `srcN_rd` = `tx_req` & (`grant` == N), combinational.
  - The timeout counter increments every cycle.
  - If `tx_done` = 1: pulse `srcN_done` with `srcN_err` = 0, clear the counter, and go to IFG.
  - Else if the counter reaches TIMEOUT_CYCLES − 1: pulse `srcN_done` with `srcN_err` = 1, and go to IFG.
- IFG:
  - Count IFG_CYCLES cycles, then go to IDLE.
  - `tx_req` and `tx_done` are ignored here.
- `tx_byte_num` holds its value from START until the next grant. This matters because the engine samples it one cycle after the start pulse.
- A source may drop `srcN_req` mid-frame. The frame still completes and `srcN_done` is still pulsed.
- When no source is granted, `tx_data` = 0 and `srcN_rd` = 0.
- Reset at any time forces IDLE and returns every output to its reset value. An engine frame in progress is not cancelled by this block.

## Timing
- Reset values:
  - `tx_start_en`, `busy`, all `srcN_rd`, `srcN_done`, `srcN_err`: 0.
  - `tx_byte_num` = 0, `tx_data` = 0.
  - State = IDLE, `last_grant` = 1.
- Request sampled in IDLE at cycle t:
  - START at t+1 with `tx_start_en` high and `tx_byte_num` valid.
  - BUSY from t+2.
- `tx_done` at cycle d: `srcN_done` at d+1 and IFG from d+1.
- Next `tx_start_en` no earlier than d+IFG_CYCLES+3. `tx_start_en` therefore stays low for at least 2 cycles between pulses, as the engine's edge detector requires.
- `srcN_rd` has zero latency from `tx_req`. The source must present the next word on `srcN_data` by the cycle after `srcN_rd`; the engine consumes the word two cycles after `tx_req`.
- `done` and `err` are registered outputs, one cycle wide.
- Rejection: a request seen in IDLE at t gives `srcN_done` = `srcN_err` = 1 at t+1.
- If the same bad request is still high, it is re-evaluated after the `srcN_done` pulse. It is re-rejected only if the source keeps it asserted; sources drop `req` on `done`.
- `tx_done` in the same cycle as timeout expiry counts as success.

## Test plan
- Single request, `src0` with byte_num = 100: `tx_start_en` pulses once, `tx_byte_num` = 100. Return `tx_done` 200 cycles later: `src0_done` = 1 and `src0_err` = 0 one cycle after, and `busy` falls 12 cycles after that.
- Both requests high from reset: `src0` is granted first, then `src1`. The two `tx_start_en` pulses are separated by at least frame length + IFG_CYCLES + 3.
- `src1` requests continuously while `src0` re-requests after each done: grants alternate 0,1,0,1 with no starvation.
- `tx_req` pulses while `src1` is granted: `src1_rd` mirrors every pulse and `src0_rd` stays 0. `tx_data` equals `src1_data` (e.g. 32'hA5A5_0102).
- Zero-length and oversize requests: byte_num = 0 and byte_num = 1473 each give `done` + `err` one cycle later with no `tx_start_en`.
- Timeout and reset:
  - With TIMEOUT_CYCLES = 50 and no `tx_done`: `src0_done` + `src0_err` 50 cycles after BUSY entry. A late `tx_done` during IFG produces no `done`.
  - `rst_n` low in mid-BUSY: all outputs return to their reset values immediately.
